// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   rs_state_t  : sequencer FSM states
//   MAX_DOMAINS : upper bound on the number of sequenced domains
//   max3        : largest of three integers, used to size the shared timer
package reset_seq_pkg;

   localparam int MAX_DOMAINS = 8;

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      RELEASE  = 3'd1,
      WAIT_ACK = 3'd2,
      GAP      = 3'd3,
      RUN      = 3'd4,
      FAULT    = 3'd5
   } rs_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Clearable, saturating up-counter with a terminal-count compare.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset (count -> 0)
//   clr_i   : clear count to 0 (wins over en_i)
//   en_i    : increment count (holds at all-ones, never wraps)
//   term_i  : terminal value to compare against
//   tc_o    : count equals term_i
module reset_seq_timer #(
   parameter int TW = 4
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [TW-1:0] term_i,
   output logic          tc_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// Releases up to eight downstream reset domains one after another, waiting
// for each domain's ready acknowledge before moving to the next.
//   clk_i          : clock
//   rst_n_i        : synchronous active-low reset (from board reset synchronizer)
//   sw_rst_req_i   : single-cycle request to re-run the whole sequence
//   domain_ack_i   : per-domain ready acknowledge, synchronous to clk_i
//   domain_rst_n_o : per-domain active-low reset
//   all_ready_o    : every domain released and acknowledged
//   busy_o         : sequence in progress (including HOLD)
//   fault_o        : acknowledge timeout latched
//   fault_domain_o : index of the domain that timed out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HOLD     | all domains in reset, timer counts HOLD_CYCLES
// RELEASE  | one cycle: release domain idx, clear timer
// WAIT_ACK | wait for ack of domain idx, timer bounds the wait
// GAP      | idle GAP_CYCLES before releasing the next domain
// RUN      | all domains up; watch for lost acks
// FAULT    | ack timeout; all domains forced into reset until sw request
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int ACK_TIMEOUT = 1024,
   localparam int FDW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   sw_rst_req_i,
   input  logic [NUM_DOMAINS-1:0] domain_ack_i,
   output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
   output logic                   all_ready_o,
   output logic                   busy_o,
   output logic                   fault_o,
   output logic [FDW-1:0]         fault_domain_o
);

   localparam int TW = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);

   localparam logic [TW-1:0]  HOLD_TC  = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]  GAP_TC   = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]  ACK_TC   = TW'(ACK_TIMEOUT - 1);
   localparam logic [FDW-1:0] LAST_IDX = FDW'(NUM_DOMAINS - 1);

   rs_state_t              state_q, state_d;
   logic [FDW-1:0]         idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
   logic                   all_ready_q, all_ready_d;
   logic                   busy_q, busy_d;
   logic                   fault_q, fault_d;
   logic [FDW-1:0]         fault_dom_q, fault_dom_d;

   logic                   timer_clr, timer_en, timer_tc;
   logic [TW-1:0]          timer_term;

   logic [NUM_DOMAINS-1:0] ack_guard;
   logic                   ack_lost;
   logic                   ack_cur;

   reset_seq_timer #(
      .TW(TW)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (timer_clr),
      .en_i    (timer_en),
      .term_i  (timer_term),
      .tc_o    (timer_tc)
   );

   // Domains whose acknowledge must stay high: those below idx while
   // waiting or gapping, and every domain once running.
   always_comb begin
      ack_guard = '0;
      for (int j = 0; j < NUM_DOMAINS; j++) begin
         case (state_q)
            WAIT_ACK, GAP: ack_guard[j] = (FDW'(j) < idx_q);
            RUN:           ack_guard[j] = 1'b1;
            default:       ack_guard[j] = 1'b0;
         endcase
      end
      ack_lost = |(ack_guard & ~domain_ack_i);
      ack_cur  = domain_ack_i[idx_q];
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dom_rst_n_d = dom_rst_n_q;
      timer_clr   = 1'b0;
      timer_en    = 1'b0;
      timer_term  = HOLD_TC;

      if (sw_rst_req_i || ack_lost) begin
         state_d     = HOLD;
         idx_d       = '0;
         dom_rst_n_d = '0;
         timer_clr   = 1'b1;
      end else begin
         case (state_q)
            HOLD: begin
               timer_en   = 1'b1;
               timer_term = HOLD_TC;
               if (timer_tc) state_d = RELEASE;
            end
            RELEASE: begin
               dom_rst_n_d[idx_q] = 1'b1;
               timer_clr          = 1'b1;
               state_d            = WAIT_ACK;
            end
            WAIT_ACK: begin
               timer_term = ACK_TC;
               // An ack on the timeout edge still counts as success.
               if (ack_cur) begin
                  timer_clr = 1'b1;
                  state_d   = (idx_q == LAST_IDX) ? RUN : GAP;
               end else if (timer_tc) begin
                  state_d     = FAULT;
                  dom_rst_n_d = '0;
               end else begin
                  timer_en = 1'b1;
               end
            end
            GAP: begin
               timer_en   = 1'b1;
               timer_term = GAP_TC;
               if (timer_tc) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = RELEASE;
               end
            end
            RUN: begin
            end
            FAULT: begin
               dom_rst_n_d = '0;
            end
            default: begin
               state_d     = HOLD;
               idx_d       = '0;
               dom_rst_n_d = '0;
               timer_clr   = 1'b1;
            end
         endcase
      end

      // Status outputs are registered copies of the state being entered.
      all_ready_d = (state_d == RUN);
      fault_d     = (state_d == FAULT);
      busy_d      = !((state_d == RUN) || (state_d == FAULT));
      fault_dom_d = (state_d == FAULT) ? idx_d : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= HOLD;
         idx_q       <= '0;
         dom_rst_n_q <= '0;
         all_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         fault_q     <= 1'b0;
         fault_dom_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dom_rst_n_q <= dom_rst_n_d;
         all_ready_q <= all_ready_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         fault_dom_q <= fault_dom_d;
      end
   end

   assign domain_rst_n_o = dom_rst_n_q;
   assign all_ready_o    = all_ready_q;
   assign busy_o         = busy_q;
   assign fault_o        = fault_q;
   assign fault_domain_o = fault_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: every clock edge the stimulus side
// advances a behavioural model (counts of released/acknowledged domains and
// countdowns) and queues the expected outputs; a monitor on the falling
// edge pops and compares.
module tb_reset_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int TMO  = 8;
   localparam int FDW  = (N > 1) ? $clog2(N) : 1;

   logic           clk_i = 1'b0;
   logic           rst_n_i;
   logic           sw_rst_req_i;
   logic [N-1:0]   domain_ack_i;
   logic [N-1:0]   domain_rst_n_o;
   logic           all_ready_o;
   logic           busy_o;
   logic           fault_o;
   logic [FDW-1:0] fault_domain_o;

   always #5 clk_i = ~clk_i;

   reset_sequencer #(
      .NUM_DOMAINS (N),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .sw_rst_req_i   (sw_rst_req_i),
      .domain_ack_i   (domain_ack_i),
      .domain_rst_n_o (domain_rst_n_o),
      .all_ready_o    (all_ready_o),
      .busy_o         (busy_o),
      .fault_o        (fault_o),
      .fault_domain_o (fault_domain_o)
   );

   typedef struct {
      logic [N-1:0] rst_n;
      bit           rdy;
      bit           busy;
      bit           flt;
      bit           chk_fdom;
      int           fdom;
      int           edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: how many domains are released / acknowledged, how
   // many idle edges remain before the next release, and how long the
   // current domain has been waited on.
   int m_edge   = 0;
   int m_rel    = 0;
   int m_acked  = 0;
   int m_pre    = HOLD;
   int m_waited = 0;
   int m_fdom   = 0;
   bit m_gap    = 0;
   bit m_wait   = 0;
   bit m_fault  = 0;
   int rel_edge[N];
   int dly[N];

   function automatic void m_restart();
      m_rel    = 0;
      m_acked  = 0;
      m_pre    = HOLD;
      m_gap    = 0;
      m_wait   = 0;
      m_waited = 0;
      m_fault  = 0;
      m_fdom   = 0;
   endfunction

   function automatic bit m_lost(input logic [N-1:0] ack);
      int lim;
      lim = 0;
      if (m_acked == N)              lim = N;
      else if (m_wait)               lim = m_acked;
      else if (m_gap && m_pre > 0)   lim = m_acked - 1;
      for (int j = 0; j < lim; j++)
         if (!ack[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_edge(input bit rn, input bit sw, input logic [N-1:0] ack);
      exp_t e;
      bit   in_rst;
      m_edge++;
      in_rst = !rn;
      if (!rn || sw) begin
         m_restart();
      end else if (m_fault) begin
      end else if (m_lost(ack)) begin
         m_restart();
      end else if (m_acked == N) begin
      end else if (m_wait) begin
         if (ack[m_rel-1]) begin
            m_acked++;
            m_wait = 0;
            if (m_acked < N) begin
               m_pre = GAP;
               m_gap = 1;
            end
         end else begin
            m_waited++;
            if (m_waited == TMO) begin
               m_fault = 1;
               m_fdom  = m_rel - 1;
            end
         end
      end else if (m_pre > 0) begin
         m_pre--;
      end else begin
         rel_edge[m_rel] = m_edge;
         m_rel++;
         m_wait   = 1;
         m_waited = 0;
         m_gap    = 0;
      end
      for (int i = 0; i < N; i++) e.rst_n[i] = !m_fault && (i < m_rel);
      e.rdy      = (m_acked == N) && !m_fault;
      e.flt      = m_fault;
      e.busy     = !e.rdy && !m_fault;
      e.fdom     = m_fault ? m_fdom : 0;
      e.chk_fdom = m_fault || in_rst;
      e.edge_no  = m_edge;
      exp_q.push_back(e);
   endfunction

   // Acks rise dly[i] edges after domain i's release edge; unreleased
   // domains get random noise when junk is set.
   function automatic logic [N-1:0] gen_ack(input bit junk);
      logic [N-1:0] a;
      for (int i = 0; i < N; i++) begin
         if (i < m_rel && !m_fault) a[i] = ((m_edge + 1 - rel_edge[i]) >= dly[i]);
         else                       a[i] = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      return a;
   endfunction

   task automatic step(input bit rn, input bit sw, input logic [N-1:0] ack);
      rst_n_i      = rn;
      sw_rst_req_i = sw;
      domain_ack_i = ack;
      @(posedge clk_i);
      model_edge(rn, sw, ack);
      #1;
   endtask

   task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s @edge %0d: dut=%0h model=%0h", nm, e, act, expv);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: condition not reached within bound", nm);
   endtask

   exp_t mon_e;
   always @(negedge clk_i) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("domain_rst_n", mon_e.edge_no, 32'(domain_rst_n_o), 32'(mon_e.rst_n));
         chk("all_ready",    mon_e.edge_no, 32'(all_ready_o),    32'(mon_e.rdy));
         chk("busy",         mon_e.edge_no, 32'(busy_o),         32'(mon_e.busy));
         chk("fault",        mon_e.edge_no, 32'(fault_o),        32'(mon_e.flt));
         if (mon_e.chk_fdom)
            chk("fault_domain", mon_e.edge_no, 32'(fault_domain_o), 32'(mon_e.fdom));
      end
   end

   logic [N-1:0] a;
   bit           hit;
   bit           rn_r, sw_r;
   int           prev_rel;

   initial begin
      rst_n_i      = 1'b0;
      sw_rst_req_i = 1'b0;
      domain_ack_i = '0;
      for (int i = 0; i < N; i++) begin
         dly[i]      = 3;
         rel_edge[i] = 0;
      end

      // Reset, then nominal sequence with acks 3 cycles after release
      repeat (3) step(1'b0, 1'b0, '0);
      repeat (30) step(1'b1, 1'b0, gen_ack(1'b0));

      // Lost ack in RUN for one cycle
      a = gen_ack(1'b0);
      a[0] = 1'b0;
      step(1'b1, 1'b0, a);
      repeat (30) step(1'b1, 1'b0, gen_ack(1'b0));

      // Timeout on domain 1, then software restart
      dly[1] = 1000;
      step(1'b1, 1'b1, '0);
      repeat (35) step(1'b1, 1'b0, gen_ack(1'b0));
      dly[1] = 3;
      step(1'b1, 1'b1, gen_ack(1'b0));
      repeat (30) step(1'b1, 1'b0, gen_ack(1'b0));

      // Software request during GAP
      step(1'b1, 1'b1, '0);
      hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
         a = gen_ack(1'b0);
         if (m_gap && m_pre > 0 && !m_wait && m_acked < N) begin
            step(1'b1, 1'b1, a);
            hit = 1;
         end else begin
            step(1'b1, 1'b0, a);
         end
      end
      if (!hit) bound_fail("sw_in_gap");

      // Software request on the same edge as an ack
      hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
         a = gen_ack(1'b0);
         if (m_wait && !m_fault && a[m_rel-1]) begin
            step(1'b1, 1'b1, a);
            hit = 1;
         end else begin
            step(1'b1, 1'b0, a);
         end
      end
      if (!hit) bound_fail("sw_with_ack");

      // rst_n low for one cycle while waiting on domain 1
      hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
         a = gen_ack(1'b0);
         if (m_wait && m_rel == 2) begin
            step(1'b0, 1'b0, a);
            hit = 1;
         end else begin
            step(1'b1, 1'b0, a);
         end
      end
      if (!hit) bound_fail("rst_in_wait");
      repeat (30) step(1'b1, 1'b0, gen_ack(1'b0));

      // Domain 1 acks exactly on the timeout edge; domain 2 one edge late
      dly[0] = 3;
      dly[1] = TMO;
      dly[2] = TMO + 1;
      step(1'b1, 1'b1, '0);
      repeat (40) step(1'b1, 1'b0, gen_ack(1'b0));
      for (int i = 0; i < N; i++) dly[i] = 2;
      step(1'b1, 1'b1, gen_ack(1'b0));
      repeat (25) step(1'b1, 1'b0, gen_ack(1'b0));

      // Randomised traffic
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, TMO + 1);
      for (int c = 0; c < 1500; c++) begin
         rn_r = ($urandom_range(0, 299) != 0);
         sw_r = ($urandom_range(0, 79) == 0) || (m_fault && $urandom_range(0, 9) == 0);
         a = gen_ack(1'b1);
         if ($urandom_range(0, 59) == 0) a[$urandom_range(0, N - 1)] = 1'b0;
         prev_rel = m_rel;
         step(rn_r, sw_r, a);
         if (m_rel > prev_rel) dly[m_rel-1] = $urandom_range(1, TMO + 1);
      end

      @(negedge clk_i);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
